// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: IMEM request/response, redirect input and the decode-side handshake.
// The master modport is the fetch queue itself; slave is the IMEM/decode environment.
interface if_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic [CW-1:0]   fifo_count;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst, fifo_count,
    input  imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, fifo_count,
    output imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one IMEM word request per cycle and
// buffers {pc, inst} responses in a circular FIFO for decode; redirects flush everything in flight.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_fetch_queue_if.master     bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight_v;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_redirect_aligned;
  logic [CW1-1:0]  w_credit;
  logic            w_has_credit;
  logic            w_unused;

  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

  assign w_valid = (r_count != '0) & ~bus.redirect_valid;
  assign w_pop   = w_valid & bus.if_ready;
  // A redirect drops the response landing this cycle; it belongs to the old stream.
  assign w_push  = r_inflight_v & ~bus.redirect_valid;

  // Occupancy once the outstanding fetch lands; a pop never underflows because it implies count>=1.
  assign w_credit     = {1'b0, r_count} + CW1'(r_inflight_v) - CW1'(w_pop);
  assign w_has_credit = w_credit < CW1'(DEPTH);

  assign w_redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_req  = rst_n & (bus.redirect_valid | w_has_credit);
  assign w_addr = bus.redirect_valid ? w_redirect_aligned : r_fetch_pc;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = w_addr;
  assign bus.if_valid   = w_valid;
  assign bus.if_pc      = r_pc_mem[r_rd_ptr];
  assign bus.if_inst    = r_inst_mem[r_rd_ptr];
  assign bus.fifo_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_inflight_v <= 1'b0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_inflight_v <= w_req;
      if (w_req) begin
        r_fetch_pc <= w_addr + XLEN'(4);
      end

      if (bus.redirect_valid) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by count and inflight_v.
  always_ff @(posedge clk) begin
    if (w_req) begin
      r_inflight_pc <= w_addr;
    end
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
      r_inst_mem[r_wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: hand sequences for reset, backpressure, flush and reset
// mid-operation, a redirect vector table, and a delivery-order model checked on every pop.
module tb_if_fetch_queue;

  localparam int              XLEN     = 32;
  localparam int              DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] pc2;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] mon_exp;
  logic [31:0] p;
  vec_t vecs [5];

  if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  if_fetch_queue #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0000_0013 + ((pc >> 2) << 20);
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= inst_of(bus.imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Delivery model: every accepted head must be the next PC of the current stream.
  task automatic monitor();
    if (!rst_n) begin
      mon_exp = RESET_PC;
    end else if (bus.redirect_valid) begin
      mon_exp = {bus.redirect_pc[31:2], 2'b00};
    end else if (bus.if_valid && bus.if_ready) begin
      chk("mon_pc", bus.if_pc, mon_exp);
      chk("mon_inst", bus.if_inst, inst_of(mon_exp));
      mon_exp = mon_exp + 32'd4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mon_exp = RESET_PC;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;

    vecs[0] = '{rpc: 32'h0000_0010, addr: 32'h0000_0010, pc0: 32'h0000_0010, pc1: 32'h0000_0014, pc2: 32'h0000_0018};
    vecs[1] = '{rpc: 32'h0000_0203, addr: 32'h0000_0200, pc0: 32'h0000_0200, pc1: 32'h0000_0204, pc2: 32'h0000_0208};
    vecs[2] = '{rpc: 32'hFFFF_FFF8, addr: 32'hFFFF_FFF8, pc0: 32'hFFFF_FFF8, pc1: 32'hFFFF_FFFC, pc2: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_0807, addr: 32'h0000_0804, pc0: 32'h0000_0804, pc1: 32'h0000_0808, pc2: 32'h0000_080C};
    vecs[4] = '{rpc: 32'hFFFF_FFFF, addr: 32'hFFFF_FFFC, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000, pc2: 32'h0000_0004};

    tick(); tick(); tick();
    #2;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);

    // Reset release and streaming
    tick(); rst_n = 1'b1; #2;
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr", bus.imem_addr, RESET_PC);
    chk("t1_valid_c0", 32'(bus.if_valid), 32'd0);
    tick(); #2;
    chk("t1_valid_c1", 32'(bus.if_valid), 32'd0);
    tick(); #2;
    chk("t1_valid_c2", 32'(bus.if_valid), 32'd1);
    chk("t1_pc0", bus.if_pc, 32'h0);
    chk("t1_inst0", bus.if_inst, 32'h0000_0013);
    p = 32'd4;
    for (int k = 0; k < 6; k++) begin
      tick(); #2;
      chk("t1_stream_valid", 32'(bus.if_valid), 32'd1);
      chk("t1_stream_pc", bus.if_pc, p);
      p = p + 32'd4;
    end

    // Flush with three buffered entries and one in flight
    tick(); bus.if_ready = 1'b0; #2;
    chk("t3_hold_pc", bus.if_pc, p);
    tick(); #2;
    chk("t3_hold_pc", bus.if_pc, p);
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100; #2;
    chk("t3_count_pre", 32'(bus.fifo_count), 32'd3);
    chk("t3_valid_r", 32'(bus.if_valid), 32'd0);
    chk("t3_req_r", 32'(bus.imem_req), 32'd1);
    chk("t3_addr_r", bus.imem_addr, 32'h0000_0100);
    tick(); bus.redirect_valid = 1'b0; bus.if_ready = 1'b1; #2;
    chk("t3_valid_r1", 32'(bus.if_valid), 32'd0);
    chk("t3_count_r1", 32'(bus.fifo_count), 32'd0);
    tick(); #2;
    chk("t3_valid_r2", 32'(bus.if_valid), 32'd1);
    chk("t3_pc_r2", bus.if_pc, 32'h0000_0100);
    tick(); #2;
    chk("t3_pc_r3", bus.if_pc, 32'h0000_0104);
    p = 32'h0000_0108;

    // Backpressure for ten cycles
    tick(); bus.if_ready = 1'b0; #2;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) begin
        tick(); #2;
      end
      chk("t2_hold_pc", bus.if_pc, p);
      chk("t2_hold_inst", bus.if_inst, inst_of(p));
      if (i >= 3) begin
        chk("t2_count_full", 32'(bus.fifo_count), 32'd4);
        chk("t2_req_off", 32'(bus.imem_req), 32'd0);
      end
    end
    tick(); bus.if_ready = 1'b1; #2;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        tick(); #2;
      end
      chk("t2_resume_valid", 32'(bus.if_valid), 32'd1);
      chk("t2_resume_pc", bus.if_pc, p);
      p = p + 32'd4;
    end

    // Redirect vector table (alignment and wrap-around)
    for (int v = 0; v < 5; v++) begin
      tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = vecs[v].rpc; #2;
      chk("tv_valid_r", 32'(bus.if_valid), 32'd0);
      chk("tv_req_r", 32'(bus.imem_req), 32'd1);
      chk("tv_addr_r", bus.imem_addr, vecs[v].addr);
      tick(); bus.redirect_valid = 1'b0; #2;
      chk("tv_valid_r1", 32'(bus.if_valid), 32'd0);
      chk("tv_count_r1", 32'(bus.fifo_count), 32'd0);
      tick(); #2;
      chk("tv_valid_r2", 32'(bus.if_valid), 32'd1);
      chk("tv_pc0", bus.if_pc, vecs[v].pc0);
      chk("tv_inst0", bus.if_inst, inst_of(vecs[v].pc0));
      tick(); #2;
      chk("tv_pc1", bus.if_pc, vecs[v].pc1);
      tick(); #2;
      chk("tv_pc2", bus.if_pc, vecs[v].pc2);
    end

    // Back-to-back redirects, the second wins
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0203; #2;
    chk("t4_addr_r", bus.imem_addr, 32'h0000_0200);
    chk("t4_valid_r", 32'(bus.if_valid), 32'd0);
    tick(); bus.redirect_pc = 32'h0000_0400; #2;
    chk("t4_addr_r1", bus.imem_addr, 32'h0000_0400);
    chk("t4_valid_r1", 32'(bus.if_valid), 32'd0);
    tick(); bus.redirect_valid = 1'b0; #2;
    chk("t4_valid_r2", 32'(bus.if_valid), 32'd0);
    tick(); #2;
    chk("t4_valid_r3", 32'(bus.if_valid), 32'd1);
    chk("t4_pc_r3", bus.if_pc, 32'h0000_0400);
    tick(); #2;
    chk("t4_pc_r4", bus.if_pc, 32'h0000_0404);

    // Asynchronous reset with a full FIFO
    tick(); bus.if_ready = 1'b0;
    repeat (5) tick();
    #2;
    chk("t6_count_full", 32'(bus.fifo_count), 32'd4);
    chk("t6_valid_full", 32'(bus.if_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(bus.if_valid), 32'd0);
    chk("t6_req_rst", 32'(bus.imem_req), 32'd0);
    chk("t6_count_rst", 32'(bus.fifo_count), 32'd0);
    tick();
    tick(); rst_n = 1'b1; bus.if_ready = 1'b1; #2;
    chk("t6_req_rel", 32'(bus.imem_req), 32'd1);
    chk("t6_addr_rel", bus.imem_addr, RESET_PC);
    tick(); #2;
    chk("t6_valid_c1", 32'(bus.if_valid), 32'd0);
    tick(); #2;
    chk("t6_valid_c2", 32'(bus.if_valid), 32'd1);
    chk("t6_pc_c2", bus.if_pc, RESET_PC);
    chk("t6_inst_c2", bus.if_inst, 32'h0000_0013);
    tick(); #2;
    chk("t6_pc_c3", bus.if_pc, RESET_PC + 32'd4);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end. It replaces the bare Program_Counter -> Adder(+4) -> IMEM chain.
- Owns the fetch PC and issues one word request per cycle to a synchronous (1-cycle read latency) IMEM.
- Buffers returned {pc, inst} pairs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap) with flush of buffered and in-flight fetches.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  word-aligned fetch address, bits [1:0] always 0.
- imem_rdata  in  XLEN  instruction, valid the cycle after imem_req.
- redirect_valid  in  1  redirect fetch stream this cycle.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts head.
- if_pc  out  XLEN  PC of head entry.
- if_inst  out  XLEN  instruction of head entry.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, count=0, inflight_v=0.
  - imem_req=0, if_valid=0, fifo_count=0.
  - if_pc, if_inst and imem_addr hold no meaningful value and must be ignored.
  - Reset mid-operation discards all buffered and in-flight fetches.
- Request rule (combinational):
  - pop = if_valid & if_ready.
  - imem_req = rst_n & (redirect_valid | (count + inflight_v - pop < DEPTH)).
  - This credit check guarantees the FIFO never overflows.
- Address:
  - imem_addr = redirect_valid ? {redirect_pc[XLEN-1:2],2'b00} : fetch_pc.
  - Redirect is bypassed into the same-cycle request.
- On a cycle with imem_req=1:
  - At the clock edge, inflight_v<=1, inflight_pc<=imem_addr, fetch_pc<=imem_addr+4.
  - The +4 is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0x0000_0000.
- On a cycle with imem_req=0:
  - At the clock edge, inflight_v<=0 and fetch_pc holds.
- Response:
  - When inflight_v=1 and redirect_valid=0, push {inflight_pc, imem_rdata} into the FIFO at the clock edge.
- Latency:
  - A request in cycle N gives if_valid=1 for that entry in cycle N+2 at the earliest.
  - There is no FIFO bypass; an empty FIFO shows its new entry one cycle after the push.
- Throughput: with if_ready held at 1, one instruction per cycle in steady state for any DEPTH≥2.
- Handshake:
  - Head is popped on if_valid & if_ready.
  - if_pc and if_inst stay stable while if_valid=1 and if_ready=0.
  - if_valid = (count!=0) & ~redirect_valid. It is forced low in a redirect cycle, so no pop occurs then.
- Redirect (cycle R):
  - FIFO is flushed (count<=0).
  - The response arriving in R, from a request in R-1, is dropped.
  - A request is issued at the aligned redirect_pc regardless of credit.
  - fetch_pc<=aligned redirect_pc+4.
  - First post-redirect if_valid occurs in cycle R+2.
  - Back-to-back redirects: each one wins, and the last one determines the stream.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - On a full FIFO a push cannot coincide without a pop, by the credit rule.
- FIFO storage uses circular read/write pointers that wrap at DEPTH. Registers are reset only where listed above.

Test Plan:
1. Reset and stream: RESET_PC=0, DEPTH=4, IMEM word i = 0x0000_0013 + (i<<20), if_ready=1; release rst_n.
   - Required: imem_req rises in the first cycle.
   - Required: if_valid is first seen two cycles later with if_pc=0x0 and if_inst=0x0000_0013.
   - Required: then if_pc=0x4, 0x8, ... one per cycle with no bubbles.
2. Backpressure: drop if_ready for 10 cycles mid-stream.
   - Required: fifo_count saturates at 4 and imem_req deasserts.
   - Required: if_pc and if_inst stay stable.
   - Required: after if_ready=1 the PC sequence continues with no gap or duplicate.
3. Redirect flush: with FIFO holding 3 entries and one in flight, pulse redirect_valid with redirect_pc=0x100.
   - Required: if_valid=0 in that cycle.
   - Required: the old entries never appear.
   - Required: next accepted if_pc=0x100 two cycles later, then 0x104.
4. Misaligned and back-to-back redirects: redirect_pc=0x203 in cycle R, then 0x400 in R+1.
   - Required: imem_addr=0x200 in R and 0x400 in R+1.
   - Required: first if_pc=0x400; 0x200 is never delivered.
5. Wrap-around: redirect to 0xFFFF_FFF8.
   - Required: delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Reset mid-operation: assert rst_n=0 asynchronously while FIFO is full and if_ready=0.
   - Required: if_valid, imem_req and fifo_count go 0 immediately.
   - Required: after release, fetch restarts at RESET_PC.
